norm_dispatch_ctrl: RTL

//  Schedules a shared I/Q normalizer pipeline among N_CH readout channels.

---
 rtl/norm_pkg.sv | 25 ++
 rtl/norm_rr_arbiter.sv | 50 +++++
 rtl/norm_dispatch_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/norm_pkg.sv
// norm_pkg
//   Shared constants and types for the normalizer dispatch controller.
//   N_CH        number of requesting readout channels
//   CH_W        channel-id width (clog2 of N_CH)
//   IN_W        accumulated word width, {Q[31:0], I[31:0]}
//   RES_W       normalized word width, {Q[17:0], I[17:0]}
//   RES_LAT     normalizer latency from launch to valid result
//   FIFO_DEPTH  output FIFO entries (power of 2)
//   tag_t       {vld, ch} tag that travels alongside the normalizer
package norm_pkg;

  localparam int N_CH       = 4;
  localparam int CH_W       = 2;
  localparam int IN_W       = 64;
  localparam int RES_W      = 36;
  localparam int RES_LAT    = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
  } tag_t;

endpackage

// File: rtl/norm_rr_arbiter.sv
// norm_rr_arbiter
//   Round-robin arbiter: picks the first requesting channel at or after the
//   registered pointer, then moves the pointer just past the winner.
//   clk, rst_n  clock and synchronous active-low reset
//   en          arbitration allowed this cycle (issue credit available)
//   req         per-channel request
//   grant       one-hot grant (combinational)
//   grant_ch    index of the granted channel
//   grant_any   a grant was made this cycle
module norm_rr_arbiter
  import norm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_ch,
  output logic            grant_any
);

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] idx;

  // Scan channels starting from rr_ptr; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_ch  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = CH_W'((int'(rr_ptr) + i) % N_CH);
      if (en && !grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_ch   = idx;
        grant_any  = 1'b1;
      end
    end
  end

  // Pointer only moves on a grant, so a credit stall leaves the order intact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + 1'b1;
    end
  end

endmodule

// File: rtl/norm_dispatch_ctrl.sv
// norm_dispatch_ctrl
//   Shares one fixed-latency I/Q normalizer among N_CH channels. Grants are
//   round-robin, each launch is tagged with its channel, and results land in
//   a show-ahead output FIFO guarded by a credit counter.
//   clk, rst_n    clock and synchronous active-low reset
//   enable        allow new grants
//   req_valid/req_data/req_ready   per-channel request handshake
//   norm_stb/norm_data             registered launch to the normalizer
//   norm_result/norm_done          normalizer result and completion pulse
//   out_valid/out_ready/out_ch/out_data   FIFO head towards the NN stage
//   busy          work in flight or buffered
//   err_done      sticky: norm_done arrived without a matching tag
module norm_dispatch_ctrl
  import norm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [N_CH*IN_W-1:0] req_data,
  output logic [N_CH-1:0]      req_ready,
  output logic                 norm_stb,
  output logic [IN_W-1:0]      norm_data,
  input  logic [RES_W-1:0]     norm_result,
  input  logic                 norm_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [RES_W-1:0]     out_data,
  output logic                 busy,
  output logic                 err_done
);

  localparam int CNT_W    = FIFO_AW + 1;
  localparam int MASK_CYC = RES_LAT + 2;
  localparam int MASK_W   = $clog2(MASK_CYC + 1);
  localparam logic [CNT_W:0]    CREDIT_MAX = FIFO_DEPTH[CNT_W:0];
  localparam logic [MASK_W-1:0] MASK_INIT  = MASK_CYC[MASK_W-1:0];

  logic [N_CH-1:0]    grant;
  logic [CH_W-1:0]    grant_ch;
  logic               grant_any;
  logic               issue_ok;
  logic [CH_W-1:0]    issue_ch;
  tag_t [RES_LAT-1:0] tag_pipe;
  tag_t               tag_in;
  tag_t               tag_tail;
  logic               tail_vld_d;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     credit_used;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               fifo_empty;
  logic [MASK_W-1:0]  mask_cnt;
  logic [RES_W-1:0]   mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]    mem_ch   [FIFO_DEPTH];

  // Every granted word owns a FIFO slot until it is read out; the
  // normalizer cannot stall, so this is what keeps the FIFO from overflowing.
  assign fifo_count  = wr_ptr - rd_ptr;
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign issue_ok    = rst_n & enable & (credit_used < CREDIT_MAX);

  norm_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (issue_ok),
    .req       (req_valid),
    .grant     (grant),
    .grant_ch  (grant_ch),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // Launch register; issue_ch shadows norm_stb so the tag lines up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      norm_stb  <= 1'b0;
      norm_data <= '0;
      issue_ch  <= '0;
    end else begin
      norm_stb <= grant_any;
      if (grant_any) begin
        norm_data <= req_data[grant_ch*IN_W +: IN_W];
        issue_ch  <= grant_ch;
      end
    end
  end

  // Tag pipe mirrors the normalizer latency; its tail marks a valid result.
  assign tag_in   = '{vld: norm_stb, ch: issue_ch};
  assign tag_tail = tag_pipe[RES_LAT-1];
  assign fifo_wr  = tag_tail.vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_pipe   <= '0;
      tail_vld_d <= 1'b0;
    end else begin
      tag_pipe   <= {tag_pipe[RES_LAT-2:0], tag_in};
      tail_vld_d <= tag_tail.vld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (grant_any && !fifo_wr) begin
      inflight <= inflight + 1'b1;
    end else if (!grant_any && fifo_wr) begin
      inflight <= inflight - 1'b1;
    end
  end

  // Show-ahead FIFO; the extra pointer bit separates full from empty.
  assign fifo_empty = (fifo_count == '0);
  assign out_valid  = !fifo_empty;
  assign fifo_rd    = out_valid & out_ready;
  assign out_ch     = fifo_empty ? '0 : mem_ch[rd_ptr[FIFO_AW-1:0]];
  assign out_data   = fifo_empty ? '0 : mem_data[rd_ptr[FIFO_AW-1:0]];
  assign busy       = (inflight != '0) | !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr[FIFO_AW-1:0]] <= norm_result;
      mem_ch[wr_ptr[FIFO_AW-1:0]]   <= tag_tail.ch;
    end
  end

  // The normalizer has no reset, so stale completions can still emerge for
  // a while after reset; the check is held off until they have flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_cnt <= MASK_INIT;
      err_done <= 1'b0;
    end else if (mask_cnt != '0) begin
      mask_cnt <= mask_cnt - 1'b1;
    end else if (norm_done && !tail_vld_d) begin
      err_done <= 1'b1;
    end
  end

endmodule
